nrdiv_seq_ctrl: RTL and testbench

Multi-cycle sequencer for unsigned non-restoring division. One shared add/subtract stage is reused across WIDTH iterations instead of unrolling one stage per quotient bit. It sits between a requesting datapath and its arithmetic resources. Operands are captured on a start/ready handshake, and the quotient and remainder are returned with a one-cycle done pulse.

---
 rtl/nrdiv_pkg.sv | 7 +
 rtl/nrdiv_addsub.sv | 9 +
 rtl/nrdiv_seq_ctrl.sv | 85 ++++++++
 tb/tb_nrdiv_seq_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/nrdiv_pkg.sv
// nrdiv_pkg: shared state encoding and counter sizing for the non-restoring divider.
package nrdiv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/nrdiv_addsub.sv
// nrdiv_addsub: combinational adder/subtractor shared by the divider iterations and correction.
module nrdiv_addsub #(parameter int W = 5) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);
    assign sum = sub ? a - b : a + b;
endmodule

// File: rtl/nrdiv_seq_ctrl.sv
// nrdiv_seq_ctrl: multi-cycle unsigned non-restoring divider sequencer.
// NRDIV_DBZ_EN adds a divide-by-zero fast path with the dbz flag.
module nrdiv_seq_ctrl import nrdiv_pkg::*; #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, state_nx;
    logic [WIDTH:0] a_reg, as_a, as_b, as_sum;
    logic as_sub, accept, zero_div, dbz_hit;
    logic [WIDTH-1:0] qr, dr;
    logic [CW-1:0] cnt;
    assign accept = start && ready;
`ifdef NRDIV_DBZ_EN
    assign zero_div = divisor == '0;
    assign dbz_hit  = dr == '0;
`else
    assign zero_div = 1'b0;
    assign dbz_hit  = 1'b0;
`endif
    assign as_a   = state == RUN ? {a_reg[WIDTH-1:0], qr[WIDTH-1]} : a_reg;
    assign as_b   = {1'b0, dr};
    assign as_sub = state == RUN && !a_reg[WIDTH];
    nrdiv_addsub #(.W(WIDTH + 1)) u_addsub (.a(as_a), .b(as_b), .sub(as_sub), .sum(as_sum));
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nx = zero_div ? FIX : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                ready    = 1'b1;
                done     = 1'b1;
                state_nx = start ? (zero_div ? FIX : RUN) : IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            qr    <= '0;
            dr    <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            a_reg <= '0;
            qr    <= dividend;
            dr    <= divisor;
            cnt   <= CW'(WIDTH);
        end else if (state == RUN) begin
            a_reg <= as_sum;
            qr    <= {qr[WIDTH-2:0], ~as_sum[WIDTH]};
            cnt   <= cnt - 1'b1;
        end else if (state == FIX) begin
            q   <= dbz_hit ? '1 : qr;
            r   <= dbz_hit ? qr : (a_reg[WIDTH] ? as_sum[WIDTH-1:0] : a_reg[WIDTH-1:0]);
            dbz <= dbz_hit;
        end
    end
endmodule

// File: tb/tb_nrdiv_seq_ctrl.sv
// tb_nrdiv_seq_ctrl: directed-vector bench for nrdiv_seq_ctrl at WIDTH=4.
module tb_nrdiv_seq_ctrl;
    logic clk = 0, rst = 1, start = 0;
    logic [3:0] dividend = 0, divisor = 0, q, r;
    logic ready, busy, done, dbz;
    int pass_cnt = 0, total_cnt = 0;

    typedef struct {
        logic [3:0] n, d, eq, er;
        logic       edbz;
        int         elat;
    } vec_t;
    vec_t vecs[9];

    nrdiv_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic wait_done(input bit pulse, output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (pulse && lat == 2) begin
                start = 1;
                dividend = 1;
                divisor = 1;
            end else if (pulse && lat == 3) start = 0;
        end
    endtask

    task automatic do_div(input logic [3:0] n, input logic [3:0] d, output int lat);
        @(negedge clk);
        dividend = n;
        divisor = d;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_done(0, lat);
    endtask

    initial begin
        int lat;
        bit seen;
`ifdef NRDIV_DBZ_EN
        vecs[0] = '{4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 2};
`else
        vecs[0] = '{4'd9, 4'd0, 4'd15, 4'd9, 1'b0, 6};
`endif
        vecs[1] = '{4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 6};
        vecs[2] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 6};
        vecs[3] = '{4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 6};
        vecs[4] = '{4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 6};
        vecs[5] = '{4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 6};
        vecs[6] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 6};
        vecs[7] = '{4'd1, 4'd15, 4'd0, 4'd1, 1'b0, 6};
        vecs[8] = '{4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 6};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dbz", dbz, 0);
        rst = 0;

        foreach (vecs[i]) begin
            do_div(vecs[i].n, vecs[i].d, lat);
            check($sformatf("lat_%0d/%0d", vecs[i].n, vecs[i].d), lat, vecs[i].elat);
            check($sformatf("q_%0d/%0d", vecs[i].n, vecs[i].d), q, vecs[i].eq);
            check($sformatf("r_%0d/%0d", vecs[i].n, vecs[i].d), r, vecs[i].er);
            check($sformatf("dbz_%0d/%0d", vecs[i].n, vecs[i].d), dbz, vecs[i].edbz);
        end

        do_div(13, 3, lat);
        check("b2b_first_q", q, 4);
        check("b2b_ready_in_done", ready, 1);
        dividend = 14;
        divisor = 4;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        check("b2b_busy_run", busy, 1);
        wait_done(1, lat);
        check("b2b_lat", lat + 1, 6);
        check("b2b_q", q, 3);
        check("b2b_r", r, 2);

        @(negedge clk);
        dividend = 13;
        divisor = 3;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_q", q, 0);
        check("mid_rst_r", r, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("mid_rst_no_done", seen, 0);

        for (int n = 0; n < 16; n++)
            for (int d = 1; d < 16; d++) begin
                do_div(4'(n), 4'(d), lat);
                check($sformatf("sweep_q_%0d/%0d", n, d), q, n / d);
                check($sformatf("sweep_r_%0d/%0d", n, d), r, n % d);
            end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
